regfile_sb: RTL
===============

# regfile_sb

Parametrised integer register file with a per-register pending-write scoreboard, write-to-read bypass, hardwired-zero register 0 and a sequential clear-on-reset sweep. It sits in the decode stage of the RISC-V core. It supplies two source operands per cycle and accepts one writeback per cycle. It also tells the hazard logic whether either source register still has an outstanding producer.

## Interface
Parameters:
- XLEN, 64, register width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 4)
- AW, $clog2(NREGS), register address width
- BYPASS, 1, 1 = same-cycle writeback forwarded to read ports; 0 = no forwarding
- CLEAR_ON_RESET, 1, 1 = zero registers 1..NREGS-1 after reset via sweep; 0 = contents left unchanged

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- RS1  in  AW  read address, port 1
- RS2  in  AW  read address, port 2
- ReadData1  out  XLEN  operand 1 (combinational)
- ReadData2  out  XLEN  operand 2 (combinational)
- RS1Pending  out  1  RS1 has an outstanding reservation
- RS2Pending  out  1  RS2 has an outstanding reservation
- RegWrite  in  1  writeback enable
- RD  in  AW  writeback address
- WriteData  in  XLEN  writeback data
- Reserve  in  1  mark ReserveAddr pending (instruction issued)
- ReserveAddr  in  AW  destination being reserved
- Ready  out  1  block accepting reads, writes and reservations

## Operation
- Storage: NREGS×XLEN array plus NREGS-bit pending vector. Register 0 reads as 0, is never written and is never pending.
- FSM states INIT and RUN.
  - reset high: state←INIT, sweep index←1, all pending bits←0.
  - If CLEAR_ON_RESET=0, state←RUN directly.
  - INIT, reset low: mem[idx]←0, idx←idx+1. On the cycle writing idx=NREGS-1, state←RUN.
- Ready = (state==RUN) & ~reset.
- While Ready=0:
  - ReadData1/2 = 0 and RS1Pending/RS2Pending = 0.
  - RegWrite and Reserve are ignored.
- RUN reads:
  - ReadDataN = 0 if RSN==0.
  - Otherwise, with BYPASS=1, RegWrite & RD==RSN gives WriteData.
  - Otherwise ReadDataN = mem[RSN].
- RUN pending outputs:
  - RSNPending = pend[RSN] & (RSN≠0).
  - With BYPASS=1, the term is also masked by ~(RegWrite & RD==RSN).
- RUN writes: at posedge, if RegWrite & RD≠0, mem[RD]←WriteData and pend[RD]←0.
- RUN reservations: at posedge, if Reserve & ReserveAddr≠0, pend[ReserveAddr]←1.
- Simultaneous RegWrite and Reserve to the same nonzero address: data is written and the pending bit ends at 1 (the new producer wins).
- Reserve to an already-pending register: it stays pending. This is legal; there is no count.
- RegWrite to a non-pending register: the data is written and the pending bit stays 0.
- Reads of the same address on both ports are independent and identical.

## Timing
- Read latency: 0 cycles (combinational from RS1/RS2, RegWrite, RD and WriteData).
- Write/reserve latency: the effect is visible via the array from the cycle after the edge. With BYPASS=1, the data is also visible in the same cycle.
- Reset timing:
  - With CLEAR_ON_RESET=1, Ready rises NREGS-1 rising edges after the first edge with reset low. For NREGS=32 that is 31 edges.
  - With CLEAR_ON_RESET=0, Ready rises immediately after reset deasserts.
- Reset asserted mid-INIT or mid-RUN: on the next edge state←INIT, idx←1 and pend←0, and the sweep restarts from register 1.
- Reset value of every output: ReadData1=0, ReadData2=0, RS1Pending=0, RS2Pending=0, Ready=0.

## Test plan
- Reset held 2 cycles, then released with CLEAR_ON_RESET=1, NREGS=32 -> Ready=0 for exactly 31 edges then 1; reads of every register return 0.
- Sweep interrupted: reset pulsed for 1 cycle when idx=10 -> Ready stays 0 for a further 31 edges and all registers read 0 afterwards.
- RUN read with bypass: RegWrite=1, RD=5, WriteData=0xDEAD_BEEF, RS1=5 in the same cycle with BYPASS=1 -> ReadData1=0xDEAD_BEEF combinationally. With BYPASS=0, old value 0 that cycle and 0xDEAD_BEEF the next.
- Register 0 write: RegWrite=1, RD=0, WriteData=0x1234 -> ReadData1 with RS1=0 stays 0. Reserve to 0 -> RS1Pending stays 0.
- Scoreboard: Reserve=1, ReserveAddr=7 -> RS2Pending=1 with RS2=7 next cycle. A later RegWrite RD=7 gives RS2Pending=0 in that cycle (BYPASS=1) and 0 thereafter.
- Collision: Reserve and RegWrite to register 9 in the same edge, WriteData=0x42 -> next cycle ReadData1=0x42 and RS1Pending=1.

Source files
------------

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Integer register file for the decode stage. Two combinational
//                read ports, one writeback port, a per-register pending-write
//                scoreboard, optional write-to-read bypass, hardwired-zero x0
//                and an optional sequential zeroing sweep after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int XLEN           = 64,
  parameter int NREGS          = 32,
  parameter int AW             = $clog2(NREGS),
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            reset,
  // read ports
  input  logic [AW-1:0]   RS1,
  input  logic [AW-1:0]   RS2,
  output logic [XLEN-1:0] ReadData1,
  output logic [XLEN-1:0] ReadData2,
  output logic            RS1Pending,
  output logic            RS2Pending,
  // writeback port
  input  logic            RegWrite,
  input  logic [AW-1:0]   RD,
  input  logic [XLEN-1:0] WriteData,
  // issue-time reservation
  input  logic            Reserve,
  input  logic [AW-1:0]   ReserveAddr,
  // block status
  output logic            Ready
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] c_LAST_IDX  = AW'(NREGS - 1);
  localparam logic [AW-1:0] c_FIRST_IDX = AW'(1);
  localparam logic [AW-1:0] c_ZERO_IDX  = '0;

  state_t            state_q;
  logic [AW-1:0]     idx_q;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic [NREGS-1:0]  pend_q;

  // Reads, writes and reservations are only honoured once the sweep is done
  // and reset is low; reset low is included so outputs go quiet in the very
  // cycle reset is raised, not one edge later.
  logic w_ready;
  assign w_ready = (state_q == ST_RUN) && !reset;
  assign Ready   = w_ready;

  logic w_wr_en;
  logic w_rsv_en;
  assign w_wr_en  = w_ready && RegWrite && (RD != c_ZERO_IDX);
  assign w_rsv_en = w_ready && Reserve  && (ReserveAddr != c_ZERO_IDX);

  // Sequencing of the clear sweep plus all array and scoreboard updates.
  // The reservation is applied after the writeback so that a producer issued
  // in the same cycle as an older producer retires keeps the register pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      idx_q   <= c_FIRST_IDX;
      pend_q  <= '0;
    end else if (state_q == ST_INIT) begin
      mem_q[idx_q] <= '0;
      idx_q        <= idx_q + c_FIRST_IDX;
      if (idx_q == c_LAST_IDX) begin
        state_q <= ST_RUN;
      end
    end else begin
      if (w_wr_en) begin
        mem_q[RD]  <= WriteData;
        pend_q[RD] <= 1'b0;
      end
      if (w_rsv_en) begin
        pend_q[ReserveAddr] <= 1'b1;
      end
    end
  end

  // Both read ports are identical; collect them into small arrays so one
  // generate body serves each.
  logic [AW-1:0]   w_rs    [2];
  logic [XLEN-1:0] w_rdata [2];
  logic            w_rpend [2];

  assign w_rs[0] = RS1;
  assign w_rs[1] = RS2;

  generate
    for (genvar p = 0; p < 2; p++) begin : g_rd_port
      logic w_is_zero;
      logic w_hit;

      assign w_is_zero = (w_rs[p] == c_ZERO_IDX);
      // A same-cycle writeback to this source forwards its data and also
      // retires the reservation as seen by the hazard logic.
      assign w_hit     = (BYPASS != 0) && RegWrite && (RD == w_rs[p]);

      // Operand select: quiet when not ready, zero for x0, else bypass or array.
      always_comb begin
        w_rdata[p] = '0;
        w_rpend[p] = 1'b0;
        if (w_ready && !w_is_zero) begin
          w_rdata[p] = w_hit ? WriteData : mem_q[w_rs[p]];
          w_rpend[p] = pend_q[w_rs[p]] && !w_hit;
        end
      end
    end
  endgenerate

  assign ReadData1  = w_rdata[0];
  assign ReadData2  = w_rdata[1];
  assign RS1Pending = w_rpend[0];
  assign RS2Pending = w_rpend[1];

endmodule
`default_nettype wire
